// File: rtl/hh_pkg.sv
// Shared types and default widths for the spike event readout path.
package hh_pkg;

  localparam int unsigned TS_W  = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MEM_W = 8;
  localparam int unsigned DEPTH = 4;

  // ISI value reported for the first event after reset or a saturated interval
  localparam logic [TS_W-1:0] ISI_NONE = '1;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  isi;
    logic [MEM_W-1:0] mem;
  } spike_event_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous FIFO of spike events; a push is accepted while full if a pop
// happens in the same cycle.
module spike_evt_fifo #(
  parameter int unsigned DEPTH = hh_pkg::DEPTH,
  parameter type         T     = hh_pkg::spike_event_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     head,
  output logic valid,
  output logic full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt_c;
  logic             valid_q;
  logic             full_q;
  logic             do_pop_c;
  logic             do_push_c;

  // Occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    do_pop_c  = pop && valid_q;
    do_push_c = push && (!full_q || do_pop_c);
    occ_nxt_c = occ_q;
    if (do_push_c && !do_pop_c) begin
      occ_nxt_c = occ_q + OCC_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      occ_nxt_c = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      occ_q   <= occ_nxt_c;
      valid_q <= (occ_nxt_c != '0);
      full_q  <= (occ_nxt_c == OCC_W'(DEPTH));
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = valid_q;
  assign full  = full_q;

endmodule

// File: rtl/spike_event_encoder.sv
// Turns spike rising edges into timestamped events with ISI and membrane
// snapshot, queued on a valid/ready stream with drop accounting.
module spike_event_encoder #(
  parameter int unsigned TS_W  = hh_pkg::TS_W,
  parameter int unsigned DEPTH = hh_pkg::DEPTH,
  parameter int unsigned CNT_W = hh_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     spike_in,
  input  logic [hh_pkg::MEM_W-1:0] membrane,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [TS_W-1:0]          ev_isi,
  output logic [hh_pkg::MEM_W-1:0] ev_mem,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         spike_cnt,
  output logic                     full
);

  import hh_pkg::*;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  isi;
    logic [MEM_W-1:0] mem;
  } evt_t;

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  isi_q;
  logic             spike_prev_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] scnt_q;

  logic evt_c;
  logic pop_c;
  logic push_c;
  logic drop_c;
  evt_t din_c;
  evt_t head;
  logic fifo_valid;
  logic fifo_full;

  // Event qualification: a drop leaves the ISI reference on the last stored event
  always_comb begin
    evt_c     = en && spike_in && !spike_prev_q;
    pop_c     = fifo_valid && ev_ready;
    push_c    = evt_c && (!fifo_full || pop_c);
    drop_c    = evt_c && fifo_full && !pop_c;
    din_c.ts  = ts_q;
    din_c.isi = isi_q;
    din_c.mem = membrane;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q         <= '0;
      isi_q        <= '1;
      spike_prev_q <= 1'b0;
      drop_q       <= '0;
      scnt_q       <= '0;
    end else begin
      ts_q         <= ts_q + TS_W'(1);
      spike_prev_q <= spike_in;
      if (push_c) begin
        isi_q <= TS_W'(1);
      end else if (isi_q != '1) begin
        isi_q <= isi_q + TS_W'(1);
      end
      if (drop_c && (drop_q != '1)) begin
        drop_q <= drop_q + CNT_W'(1);
      end
      if (push_c && (scnt_q != '1)) begin
        scnt_q <= scnt_q + CNT_W'(1);
      end
    end
  end

  spike_evt_fifo #(
    .DEPTH (DEPTH),
    .T     (evt_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (din_c),
    .pop   (pop_c),
    .head  (head),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign ev_valid  = fifo_valid;
  assign ev_ts     = head.ts;
  assign ev_isi    = head.isi;
  assign ev_mem    = head.mem;
  assign full      = fifo_full;
  assign drop_cnt  = drop_q;
  assign spike_cnt = scnt_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: per-cycle vector table plus
// hand-written reset and timestamp-wrap sequences.
module tb_spike_event_encoder;

  import hh_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        spike_in;
  logic [7:0]  membrane;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_ts;
  logic [15:0] ev_isi;
  logic [7:0]  ev_mem;
  logic [7:0]  drop_cnt;
  logic [7:0]  spike_cnt;
  logic        full;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  always #5 clk = ~clk;

  spike_event_encoder #(
    .TS_W  (16),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike_in  (spike_in),
    .membrane  (membrane),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_ts     (ev_ts),
    .ev_isi    (ev_isi),
    .ev_mem    (ev_mem),
    .drop_cnt  (drop_cnt),
    .spike_cnt (spike_cnt),
    .full      (full)
  );

  typedef struct {
    int          t;
    logic        spike;
    logic        en;
    logic        ready;
    logic [7:0]  mem;
    logic        exp_valid;
    logic [15:0] exp_ts;
    logic [15:0] exp_isi;
    logic [7:0]  exp_mem;
    logic [7:0]  exp_drop;
    logic [7:0]  exp_scnt;
    logic        exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int tt, input logic s, input logic e,
                              input logic r, input logic [7:0] m,
                              input logic v, input logic [15:0] ts,
                              input logic [15:0] isi, input logic [7:0] em,
                              input logic [7:0] d, input logic [7:0] sc,
                              input logic f);
    vec_t x;
    x.t = tt; x.spike = s; x.en = e; x.ready = r; x.mem = m;
    x.exp_valid = v; x.exp_ts = ts; x.exp_isi = isi; x.exp_mem = em;
    x.exp_drop = d; x.exp_scnt = sc; x.exp_full = f;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 32'(0));
    chk({tag, "_ts"},    32'(ev_ts), 32'(0));
    chk({tag, "_isi"},   32'(ev_isi), 32'(0));
    chk({tag, "_mem"},   32'(ev_mem), 32'(0));
    chk({tag, "_drop"},  32'(drop_cnt), 32'(0));
    chk({tag, "_scnt"},  32'(spike_cnt), 32'(0));
    chk({tag, "_full"},  32'(full), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; spike_in = 1'b0; ev_ready = 1'b1; membrane = 8'h00;
    step();
    step();
    chk_reset_state("por");
    rst_n = 1'b1;
    t = 0;

    // t, spike, en, ready, mem | valid, ts, isi, mem, drop, scnt, full
    vecs.push_back(mk(10, 1, 1, 1, 8'hA5, 1, 16'd10, 16'hFFFF, 8'hA5, 0, 1, 0));
    vecs.push_back(mk(11, 1, 1, 1, 8'h11, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(12, 1, 1, 1, 8'h12, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(13, 0, 1, 1, 8'h13, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(15, 1, 1, 1, 8'h3C, 1, 16'd15, 16'd5, 8'h3C, 0, 2, 0));
    vecs.push_back(mk(16, 0, 1, 1, 8'h3C, 0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(17, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 2, 0));
    // back-pressure: fill to full, then two drops
    vecs.push_back(mk(20, 1, 1, 0, 8'h20, 1, 16'd20, 16'd5, 8'h20, 0, 3, 0));
    vecs.push_back(mk(21, 0, 1, 0, 8'h20, 1, 16'd20, 16'd5, 8'h20, 0, 3, 0));
    vecs.push_back(mk(22, 1, 1, 0, 8'h22, 1, 16'd20, 16'd5, 8'h20, 0, 4, 0));
    vecs.push_back(mk(23, 0, 1, 0, 8'h22, 1, 16'd20, 16'd5, 8'h20, 0, 4, 0));
    vecs.push_back(mk(24, 1, 1, 0, 8'h24, 1, 16'd20, 16'd5, 8'h20, 0, 5, 0));
    vecs.push_back(mk(25, 0, 1, 0, 8'h24, 1, 16'd20, 16'd5, 8'h20, 0, 5, 0));
    vecs.push_back(mk(26, 1, 1, 0, 8'h26, 1, 16'd20, 16'd5, 8'h20, 0, 6, 1));
    vecs.push_back(mk(27, 0, 1, 0, 8'h26, 1, 16'd20, 16'd5, 8'h20, 0, 6, 1));
    vecs.push_back(mk(28, 1, 1, 0, 8'h28, 1, 16'd20, 16'd5, 8'h20, 1, 6, 1));
    vecs.push_back(mk(29, 0, 1, 0, 8'h28, 1, 16'd20, 16'd5, 8'h20, 1, 6, 1));
    vecs.push_back(mk(30, 1, 1, 0, 8'h30, 1, 16'd20, 16'd5, 8'h20, 2, 6, 1));
    vecs.push_back(mk(31, 0, 1, 0, 8'h30, 1, 16'd20, 16'd5, 8'h20, 2, 6, 1));
    // drain in order
    vecs.push_back(mk(32, 0, 1, 1, 8'h30, 1, 16'd22, 16'd2, 8'h22, 2, 6, 0));
    vecs.push_back(mk(33, 0, 1, 1, 8'h30, 1, 16'd24, 16'd2, 8'h24, 2, 6, 0));
    vecs.push_back(mk(34, 0, 1, 1, 8'h30, 1, 16'd26, 16'd2, 8'h26, 2, 6, 0));
    vecs.push_back(mk(35, 0, 1, 1, 8'h30, 0, 0, 0, 0, 2, 6, 0));
    // enable raised while spike already high: no event until next edge
    vecs.push_back(mk(40, 1, 0, 1, 8'h40, 0, 0, 0, 0, 2, 6, 0));
    vecs.push_back(mk(41, 1, 1, 1, 8'h41, 0, 0, 0, 0, 2, 6, 0));
    vecs.push_back(mk(42, 0, 1, 1, 8'h42, 0, 0, 0, 0, 2, 6, 0));
    vecs.push_back(mk(50, 1, 1, 1, 8'h50, 1, 16'd50, 16'd24, 8'h50, 2, 7, 0));
    vecs.push_back(mk(51, 0, 1, 1, 8'h50, 0, 0, 0, 0, 2, 7, 0));
    // refill, then an edge coincident with a pop while full
    vecs.push_back(mk(60, 1, 1, 0, 8'h60, 1, 16'd60, 16'd10, 8'h60, 2, 8, 0));
    vecs.push_back(mk(61, 0, 1, 0, 8'h60, 1, 16'd60, 16'd10, 8'h60, 2, 8, 0));
    vecs.push_back(mk(62, 1, 1, 0, 8'h62, 1, 16'd60, 16'd10, 8'h60, 2, 9, 0));
    vecs.push_back(mk(63, 0, 1, 0, 8'h62, 1, 16'd60, 16'd10, 8'h60, 2, 9, 0));
    vecs.push_back(mk(64, 1, 1, 0, 8'h64, 1, 16'd60, 16'd10, 8'h60, 2, 10, 0));
    vecs.push_back(mk(65, 0, 1, 0, 8'h64, 1, 16'd60, 16'd10, 8'h60, 2, 10, 0));
    vecs.push_back(mk(66, 1, 1, 0, 8'h66, 1, 16'd60, 16'd10, 8'h60, 2, 11, 1));
    vecs.push_back(mk(67, 0, 1, 0, 8'h66, 1, 16'd60, 16'd10, 8'h60, 2, 11, 1));
    vecs.push_back(mk(68, 1, 1, 1, 8'h68, 1, 16'd62, 16'd2, 8'h62, 2, 12, 1));
    vecs.push_back(mk(69, 0, 1, 0, 8'h68, 1, 16'd62, 16'd2, 8'h62, 2, 12, 1));
    vecs.push_back(mk(70, 0, 1, 1, 8'h68, 1, 16'd64, 16'd2, 8'h64, 2, 12, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      while (t < vecs[i].t) step();
      spike_in = vecs[i].spike;
      en       = vecs[i].en;
      ev_ready = vecs[i].ready;
      membrane = vecs[i].mem;
      step();
      chk($sformatf("v%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_drop", i),  32'(drop_cnt), 32'(vecs[i].exp_drop));
      chk($sformatf("v%0d_scnt", i),  32'(spike_cnt), 32'(vecs[i].exp_scnt));
      chk($sformatf("v%0d_full", i),  32'(full), 32'(vecs[i].exp_full));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_ts", i),  32'(ev_ts), 32'(vecs[i].exp_ts));
        chk($sformatf("v%0d_isi", i), 32'(ev_isi), 32'(vecs[i].exp_isi));
        chk($sformatf("v%0d_mem", i), 32'(ev_mem), 32'(vecs[i].exp_mem));
      end
    end

    // Mid-operation reset with three entries queued
    rst_n = 1'b0; ev_ready = 1'b0; spike_in = 1'b0;
    step();
    chk_reset_state("midrst");
    rst_n = 1'b1; ev_ready = 1'b1;
    t = 0;
    while (t < 3) step();
    spike_in = 1'b1; membrane = 8'h5A;
    #1;
    chk("no_comb_path", 32'(ev_valid), 32'(0));
    step();
    chk("rst_evt_valid", 32'(ev_valid), 32'(1));
    chk("rst_evt_ts",    32'(ev_ts), 32'(3));
    chk("rst_evt_isi",   32'(ev_isi), 32'(ISI_NONE));
    chk("rst_evt_mem",   32'(ev_mem), 32'(8'h5A));
    chk("rst_evt_scnt",  32'(spike_cnt), 32'(1));
    spike_in = 1'b0;
    step();
    chk("rst_evt_popped", 32'(ev_valid), 32'(0));

    // Timestamp wrap and ISI saturation over a long quiet interval
    while (t < 65540) step();
    spike_in = 1'b1; membrane = 8'h77;
    step();
    chk("wrap_valid", 32'(ev_valid), 32'(1));
    chk("wrap_ts",    32'(ev_ts), 32'(4));
    chk("wrap_isi",   32'(ev_isi), 32'(16'hFFFF));
    chk("wrap_mem",   32'(ev_mem), 32'(8'h77));
    chk("wrap_scnt",  32'(spike_cnt), 32'(2));
    spike_in = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
